ping_sequencer: RTL

- Sequences one sonar ping: settles the TX/RX switch, drives the transducer burst through h_bridge, blanks ring-down, flips to receive, then opens an ADC capture window.
- Optionally repeats pings on a fixed period.
- Sits between the I2C register file, which supplies config/start/abort, and the h_bridge, TX/RX switch and ADC capture logic in dvl_top.
- Owns the only path that drives hstate and txrx.

---
 rtl/dvl_pkg.sv | 9 +
 rtl/ping_sequencer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvl_pkg.sv
// Shared DVL types. h_bridge_state_t is the command bus from the ping sequencer to the h_bridge.
package dvl_pkg;

  typedef enum logic [1:0] {
    OFF  = 2'b00,  // all switches open
    OSCL = 2'b01   // drive the transducer burst
  } h_bridge_state_t;

endpackage

// File: rtl/ping_sequencer.sv
// Sonar ping sequencer: TX/RX switch settle, burst, ring-down blanking, receive settle, capture window.
// Optional burst watchdog clamp and sticky fault flag enabled with `define PING_SEQ_WATCHDOG_EN.
module ping_sequencer
  import dvl_pkg::*;
#(
  parameter int unsigned LEN_W            = 16,
  parameter int unsigned PERIOD_W         = 24,
  parameter int unsigned SWITCH_CYCLES    = 48,
  parameter int unsigned MAX_BURST_CYCLES = 4800
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                abort,
  input  logic                cont,
  input  logic [LEN_W-1:0]    burst_len,
  input  logic [LEN_W-1:0]    guard_len,
  input  logic [LEN_W-1:0]    listen_len,
  input  logic [PERIOD_W-1:0] period_len,
  output h_bridge_state_t     hstate,
  output logic                txrx,
  output logic                capture_en,
  output logic                busy,
  output logic                ping_done,
  output logic [15:0]         ping_count,
  output logic                fault
);

  typedef enum logic [2:0] {
    StIdle, StTxSetup, StBurst, StRingdown, StRxSettle, StListen, StHoldoff
  } state_e;

  localparam logic [LEN_W-1:0] SwitchLoad = LEN_W'(SWITCH_CYCLES - 1);

  state_e              state_q, state_d;
  logic [LEN_W-1:0]    phase_q, phase_d;
  logic [PERIOD_W-1:0] period_cnt_q;
  logic [LEN_W-1:0]    burst_q, guard_q, listen_q;
  logic [PERIOD_W-1:0] period_len_q;
  logic [LEN_W-1:0]    burst_eff;
  logic                enter_tx;
  logic                period_done;

  h_bridge_state_t hstate_d;
  logic            txrx_d, capture_en_d, busy_d, ping_done_d;

  // Zero-length burst still produces one oscillation cycle.
`ifdef PING_SEQ_WATCHDOG_EN
  localparam logic [LEN_W-1:0] MaxBurst = LEN_W'(MAX_BURST_CYCLES);
  logic burst_clamp, clamp_q, fault_q;

  always_comb begin
    burst_eff   = (burst_len == '0) ? LEN_W'(1) : burst_len;
    burst_clamp = 1'b0;
    if (burst_eff > MaxBurst) begin
      burst_eff   = MaxBurst;
      burst_clamp = 1'b1;
    end
  end
`else
  always_comb begin
    burst_eff = (burst_len == '0) ? LEN_W'(1) : burst_len;
  end
`endif

  assign enter_tx = (state_d == StTxSetup) && (state_q != StTxSetup);

  // Widened compare so period_len=0 behaves like period_len=1.
  assign period_done = ({1'b0, period_cnt_q} + (PERIOD_W+1)'(1)) >= {1'b0, period_len_q};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      phase_q <= '0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StTxSetup;
          phase_d = SwitchLoad;
        end
      end
      StTxSetup: begin
        if (phase_q == '0) begin
          state_d = StBurst;
          phase_d = burst_q - LEN_W'(1);
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end
      StBurst: begin
        if (phase_q == '0) begin
          if (guard_q != '0) begin
            state_d = StRingdown;
            phase_d = guard_q - LEN_W'(1);
          end else begin
            state_d = StRxSettle;
            phase_d = SwitchLoad;
          end
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end
      StRingdown: begin
        if (phase_q == '0) begin
          state_d = StRxSettle;
          phase_d = SwitchLoad;
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end
      StRxSettle: begin
        if (phase_q == '0) begin
          if (listen_q != '0) begin
            state_d = StListen;
            phase_d = listen_q - LEN_W'(1);
          end else begin
            state_d = StHoldoff;
            phase_d = '0;
          end
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end
      StListen: begin
        if (phase_q == '0) begin
          state_d = StHoldoff;
        end else begin
          phase_d = phase_q - LEN_W'(1);
        end
      end
      StHoldoff: begin
        if (period_done) begin
          state_d = cont ? StTxSetup : StIdle;
          phase_d = cont ? SwitchLoad : '0;
        end
      end
      default: begin
        state_d = StIdle;
        phase_d = '0;
      end
    endcase
    if (abort) begin
      state_d = StIdle;
      phase_d = '0;
    end
  end

  // Config shadow and period counter; both restart on every TX_SETUP entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      burst_q      <= '0;
      guard_q      <= '0;
      listen_q     <= '0;
      period_len_q <= '0;
      period_cnt_q <= '0;
    end else if (enter_tx) begin
      burst_q      <= burst_eff;
      guard_q      <= guard_len;
      listen_q     <= listen_len;
      period_len_q <= period_len;
      period_cnt_q <= '0;
    end else if (state_q != StIdle && period_cnt_q != '1) begin
      period_cnt_q <= period_cnt_q + PERIOD_W'(1);
    end
  end

  always_comb begin
    hstate_d     = OFF;
    txrx_d       = 1'b0;
    capture_en_d = 1'b0;
    busy_d       = (state_d != StIdle);
    ping_done_d  = (state_d == StHoldoff) && (state_q != StHoldoff);
    case (state_d)
      StTxSetup, StRingdown: txrx_d = 1'b1;
      StBurst: begin
        txrx_d   = 1'b1;
        hstate_d = OSCL;
      end
      StListen: capture_en_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hstate     <= OFF;
      txrx       <= 1'b0;
      capture_en <= 1'b0;
      busy       <= 1'b0;
      ping_done  <= 1'b0;
      ping_count <= '0;
    end else begin
      hstate     <= hstate_d;
      txrx       <= txrx_d;
      capture_en <= capture_en_d;
      busy       <= busy_d;
      ping_done  <= ping_done_d;
      if (ping_done_d) ping_count <= ping_count + 16'd1;
    end
  end

`ifdef PING_SEQ_WATCHDOG_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clamp_q <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      if (enter_tx) clamp_q <= burst_clamp;
      if (state_d == StBurst && state_q != StBurst && clamp_q) fault_q <= 1'b1;
    end
  end
  assign fault = fault_q;
`else
  assign fault = 1'b0;
`endif

`ifndef SYNTHESIS
  // Never drive the bridge on the receiver, never capture while on the driver.
  assert property (@(posedge clk) disable iff (!rst)
    (hstate != OSCL || txrx) && (!capture_en || !txrx));
`endif

endmodule
